uart_tx_serializer: RTL and testbench

Serial transmit stage for the wireless Hangman link. Sits directly downstream of the message register: it accepts one 8-bit guess/message byte through a `tx_ctrl`/`transmit_ready` handshake and shifts it out as an asynchronous 8N1 UART frame on `tx_serial`. An optional even-parity bit can be compiled in. It reports completion with a one-cycle `tx_done` pulse.

---
 rtl/hangman_pkg.sv | 6 +
 rtl/uart_baud_gen.sv | 16 +
 rtl/uart_tx_serializer.sv | 93 +++++++++
 tb/tb_uart_tx_serializer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// hangman_pkg: shared types and constants for the Hangman UART transmit path.
package hangman_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
    localparam int DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; bit_tick strobes on the last cycle of each bit, cleared while en is low.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic nRst,
    input  logic en,
    output logic bit_tick
);
    localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    logic [W-1:0] cnt;
    assign bit_tick = en && (cnt == W'(CLKS_PER_BIT - 1));
    always_ff @(posedge clk or negedge nRst)
        if (!nRst) cnt <= '0;
        else cnt <= (!en || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter with tx_ctrl/transmit_ready handshake and tx_done pulse.
// Define HANGMAN_UART_PARITY_EN to add an even-parity bit (8E1).
module uart_tx_serializer import hangman_pkg::*; #(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       tx_ctrl,
    input  logic [7:0] tx_byte,
    output logic       transmit_ready,
    output logic       tx_serial,
    output logic       tx_done,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
`ifdef HANGMAN_UART_PARITY_EN
    localparam uart_tx_state_t AFTER_DATA = PARITY;
`else
    localparam uart_tx_state_t AFTER_DATA = STOP;
`endif
    uart_tx_state_t       state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [2:0]           idx, idx_n;
    logic                 serial_n, done_n, bit_tick;

    assign transmit_ready = (state == IDLE);
    assign busy           = ~transmit_ready;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .nRst     (nRst),
        .en       (state != IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge nRst)
        if (!nRst) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            tx_serial <= LINE_IDLE;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            idx       <= idx_n;
            tx_serial <= serial_n;
            tx_done   <= done_n;
        end

    // The shift register rotates, so after all 8 data bits it holds the latched byte again for parity.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        done_n  = 1'b0;
        case (state)
            IDLE:
                if (tx_ctrl) begin
                    state_n = START;
                    shreg_n = tx_byte;
                    idx_n   = '0;
                end
            START:
                if (bit_tick) state_n = DATA;
            DATA:
                if (bit_tick) begin
                    shreg_n = {shreg[0], shreg[DATA_BITS-1:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'(DATA_BITS - 1)) state_n = AFTER_DATA;
                end
`ifdef HANGMAN_UART_PARITY_EN
            PARITY:
                if (bit_tick) state_n = STOP;
`endif
            STOP:
                if (bit_tick) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            default: state_n = IDLE;
        endcase
`ifdef HANGMAN_UART_PARITY_EN
        serial_n = (state_n == START)  ? 1'b0 :
                   (state_n == DATA)   ? shreg_n[0] :
                   (state_n == PARITY) ? ^shreg_n : LINE_IDLE;
`else
        serial_n = (state_n == START) ? 1'b0 :
                   (state_n == DATA)  ? shreg_n[0] : LINE_IDLE;
`endif
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: self-checking bench for uart_tx_serializer at 10 clocks per bit.
module tb_uart_tx_serializer;
    localparam int CPB = 10;
`ifdef HANGMAN_UART_PARITY_EN
    localparam int NB = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int L = NB * CPB;

    logic       clk = 1'b0, nRst = 1'b0, tx_ctrl = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       transmit_ready, tx_serial, tx_done, busy;
    int         checks = 0, failures = 0;

    typedef struct {
        logic [7:0] b;
        int         zeros;
        logic       par;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_FREQ(10_000_000), .BAUD(1_000_000)) dut (
        .clk            (clk),
        .nRst           (nRst),
        .tx_ctrl        (tx_ctrl),
        .tx_byte        (tx_byte),
        .transmit_ready (transmit_ready),
        .tx_serial      (tx_serial),
        .tx_done        (tx_done),
        .busy           (busy)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Line level k cycles after the accepting edge: start, data LSB first, [parity], stop, then idle.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        logic [NB-1:0] f;
`ifdef HANGMAN_UART_PARITY_EN
        f = {1'b1, ^b, b, 1'b0};
`else
        f = {1'b1, b, 1'b0};
`endif
        return (k < 1 || k > L) ? 1'b1 : f[(k - 1) / CPB];
    endfunction

    // k = 0 means idle with no frame just finished.
    task automatic check_cycle(input string tag, input logic [7:0] b, input int k);
        logic rdy;
        rdy = (k < 1 || k > L);
        chk($sformatf("%s k=%0d tx_serial", tag, k), tx_serial, exp_line(b, k));
        chk($sformatf("%s k=%0d transmit_ready", tag, k), transmit_ready, rdy);
        chk($sformatf("%s k=%0d busy", tag, k), busy, ~rdy);
        chk($sformatf("%s k=%0d tx_done", tag, k), tx_done, k == L + 1);
    endtask

    // Call at a negedge with tx_ctrl=1 and tx_byte=b driven; returns at the tx_done cycle.
    task automatic expect_frame(input logic [7:0] b, input bit drop, input int chg_at,
                                input logic [7:0] chg_val, output int lows);
        lows = 0;
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            check_cycle($sformatf("frame %02h", b), b, k);
            if (k <= L && (k - 1) % CPB == CPB / 2 && tx_serial === 1'b0) lows++;
            if (k == 1 && drop) begin
                tx_ctrl = 1'b0;
                tx_byte = ~b;
            end
            if (k == chg_at) tx_byte = chg_val;
        end
    endtask

    initial begin
        int lows, exp_lows;
        logic [7:0] r;
        vecs.push_back('{8'h41, 6, 1'b0});
        vecs.push_back('{8'h00, 8, 1'b0});
        vecs.push_back('{8'hFF, 0, 1'b0});
        vecs.push_back('{8'h07, 5, 1'b1});
        vecs.push_back('{8'h80, 7, 1'b1});
        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            vecs.push_back('{r, 8 - $countones(r), ^r});
        end

        repeat (3) @(negedge clk);
        check_cycle("reset", 8'h00, 0);
        nRst = 1'b1;
        @(negedge clk);
        check_cycle("post-reset", 8'h00, 0);

        for (int i = 0; i < 50; i++) begin
            tx_byte = 8'($urandom);
            @(negedge clk);
            check_cycle("ignored", 8'h00, 0);
        end

        foreach (vecs[i]) begin
            tx_byte = vecs[i].b;
            tx_ctrl = 1'b1;
            expect_frame(vecs[i].b, 1'b1, 0, 8'h00, lows);
            exp_lows = 1 + vecs[i].zeros + ((PAR && !vecs[i].par) ? 1 : 0);
            checks++;
            if (lows != exp_lows) begin
                failures++;
                $display("FAIL lowbits %02h: got %0d expected %0d", vecs[i].b, lows, exp_lows);
            end
            @(negedge clk);
            check_cycle("gap", 8'h00, 0);
        end

        tx_byte = 8'h41;
        tx_ctrl = 1'b1;
        expect_frame(8'h41, 1'b0, 50, 8'hA5, lows);
        expect_frame(8'hA5, 1'b1, 0, 8'h00, lows);
        @(negedge clk);
        check_cycle("after b2b", 8'h00, 0);

        tx_byte = 8'h41;
        tx_ctrl = 1'b1;
        for (int k = 1; k <= 4 * CPB + 5; k++) begin
            @(negedge clk);
            check_cycle("pre-reset 41", 8'h41, k);
            if (k == 1) tx_ctrl = 1'b0;
        end
        #1 nRst = 1'b0;
        #1;
        chk("async reset tx_serial", tx_serial, 1'b1);
        chk("async reset transmit_ready", transmit_ready, 1'b1);
        chk("async reset busy", busy, 1'b0);
        @(negedge clk);
        nRst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_cycle("after abort", 8'h00, 0);
        end
        tx_byte = 8'h55;
        tx_ctrl = 1'b1;
        expect_frame(8'h55, 1'b1, 0, 8'h00, lows);
        @(negedge clk);
        check_cycle("final idle", 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
